// File: rtl/jesd_tx_link_fsm.sv
// Single-lane JESD204B transmit link-layer sequencer: CGS, ILAS and user data
// phases driven by the receiver's SYNC~, with a free-running LMFC octet counter.
module jesd_tx_link_fsm #(
    parameter int unsigned  F       = 2,
    parameter int unsigned  K       = 32,
    parameter int unsigned  ILAS_MF = 4,
    localparam int unsigned LMFC_W  = $clog2(F * K)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sync_n,
    input  logic [111:0]      i_cfg,
    input  logic [7:0]        i_data,
    output logic              o_data_ready,
    output logic [7:0]        o_addr,
    output logic              o_k,
    output logic              o_rd_en,
    output logic [LMFC_W-1:0] o_lmfc_cnt,
    output logic              o_sync_err
);

    localparam int unsigned FK   = F * K;
    localparam int unsigned MF_W = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
    localparam int unsigned LOW_W = 2;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;

    localparam logic [LMFC_W-1:0] LMFC_LAST = LMFC_W'(FK - 1);
    localparam logic [MF_W-1:0]   MF_LAST   = MF_W'(ILAS_MF - 1);

    typedef enum logic [1:0] {
        ST_CGS       = 2'd0,
        ST_ILAS_WAIT = 2'd1,
        ST_ILAS      = 2'd2,
        ST_DATA      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sync_meta_q, sync_s_q;
    logic [LMFC_W-1:0]   lmfc_q, lmfc_d;
    logic [MF_W-1:0]     mf_q, mf_d;
    logic [LOW_W-1:0]    low_q, low_d;
    logic [7:0]          addr_q, addr_d;
    logic                k_q, k_d;
    logic                rd_en_q;
    logic [LMFC_W-1:0]   lmfc_out_q;
    logic                err_q, err_d;

    logic                lmfc_last_c;
    logic                linked_c;
    logic                lost_c;
    logic [3:0]          cfg_sel_c;
    logic [111:0]        cfg_shift_c;

    // lmfc_q is the LMFC position of the octet being produced this cycle
    assign lmfc_last_c = (lmfc_q == LMFC_LAST);
    assign lmfc_d      = lmfc_last_c ? '0 : lmfc_q + LMFC_W'(1);
    assign linked_c    = (state_q == ST_ILAS) || (state_q == ST_DATA);
    assign lost_c      = linked_c && !sync_s_q && (low_q == LOW_W'(3));

    assign cfg_sel_c   = 4'(lmfc_q - LMFC_W'(2));
    assign cfg_shift_c = i_cfg >> {cfg_sel_c, 3'b000};

    // Data is consumed in the cycle whose octet lands on the next LMFC boundary onward
    assign o_data_ready = (state_q == ST_DATA) && !lost_c;

    // SYNC~ synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= 1'b0;
            sync_s_q    <= 1'b0;
        end else begin
            sync_meta_q <= i_sync_n;
            sync_s_q    <= sync_meta_q;
        end
    end

    // State, counters and registered encoder-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CGS;
            lmfc_q     <= '0;
            mf_q       <= '0;
            low_q      <= '0;
            addr_q     <= 8'h00;
            k_q        <= 1'b0;
            rd_en_q    <= 1'b0;
            lmfc_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lmfc_q     <= lmfc_d;
            mf_q       <= mf_d;
            low_q      <= low_d;
            addr_q     <= addr_d;
            k_q        <= k_d;
            rd_en_q    <= 1'b1;
            lmfc_out_q <= lmfc_q;
            err_q      <= err_d;
        end
    end

    // Next state and octet selection
    always_comb begin
        state_d = state_q;
        mf_d    = mf_q;
        low_d   = '0;
        addr_d  = K28_5;
        k_d     = 1'b1;
        err_d   = 1'b0;

        case (state_q)
            ST_CGS: begin
                mf_d = '0;
                if (sync_s_q) begin
                    state_d = ST_ILAS_WAIT;
                end
            end
            ST_ILAS_WAIT: begin
                mf_d = '0;
                if (!sync_s_q) begin
                    state_d = ST_CGS;
                end else if (lmfc_last_c) begin
                    state_d = ST_ILAS;
                end
            end
            ST_ILAS: begin
                if (lmfc_q == '0) begin
                    addr_d = K28_0;
                    k_d    = 1'b1;
                end else if (lmfc_last_c) begin
                    addr_d = K28_3;
                    k_d    = 1'b1;
                end else if (mf_q == MF_W'(1) && lmfc_q == LMFC_W'(1)) begin
                    addr_d = K28_4;
                    k_d    = 1'b1;
                end else if (mf_q == MF_W'(1) && lmfc_q >= LMFC_W'(2)
                             && lmfc_q <= LMFC_W'(15)) begin
                    addr_d = cfg_shift_c[7:0];
                    k_d    = 1'b0;
                end else begin
                    addr_d = 8'(lmfc_q);
                    k_d    = 1'b0;
                end
                if (lmfc_last_c) begin
                    if (mf_q == MF_LAST) begin
                        state_d = ST_DATA;
                        mf_d    = '0;
                    end else begin
                        mf_d = mf_q + MF_W'(1);
                    end
                end
            end
            ST_DATA: begin
                addr_d = i_data;
                k_d    = 1'b0;
            end
            default: begin
                state_d = ST_CGS;
            end
        endcase

        // Short SYNC~ low runs are reported once sync returns high
        if (linked_c) begin
            if (!sync_s_q) begin
                low_d = low_q + LOW_W'(1);
            end else begin
                err_d = (low_q != '0);
            end
        end

        if (lost_c) begin
            state_d = ST_CGS;
            mf_d    = '0;
            low_d   = '0;
            addr_d  = K28_5;
            k_d     = 1'b1;
        end
    end

    assign o_addr     = addr_q;
    assign o_k        = k_q;
    assign o_rd_en    = rd_en_q;
    assign o_lmfc_cnt = lmfc_out_q;
    assign o_sync_err = err_q;

endmodule

// File: tb/tb_jesd_tx_link_fsm.sv
// Directed bench for jesd_tx_link_fsm (F=2, K=32, ILAS_MF=4): CGS, ILAS, data,
// SYNC~ glitch/loss handling and mid-operation reset.
module tb_jesd_tx_link_fsm;

    logic         clk;
    logic         rst_n;
    logic         i_sync_n;
    logic [111:0] i_cfg;
    logic [7:0]   i_data;
    logic         o_data_ready;
    logic [7:0]   o_addr;
    logic         o_k;
    logic         o_rd_en;
    logic [5:0]   o_lmfc_cnt;
    logic         o_sync_err;

    int n_cmp;
    int n_bad;
    int exp_cnt;
    int err_hits;
    bit pend;
    logic [7:0] pend_val;
    logic [7:0] next_val;

    jesd_tx_link_fsm #(.F(2), .K(32), .ILAS_MF(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sync_n     (i_sync_n),
        .i_cfg        (i_cfg),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_addr       (o_addr),
        .o_k          (o_k),
        .o_rd_en      (o_rd_en),
        .o_lmfc_cnt   (o_lmfc_cnt),
        .o_sync_err   (o_sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_ilas(input int m, input int j);
        if (j == 0)                          return {1'b1, 8'h1C};
        if (j == 63)                         return {1'b1, 8'h7C};
        if (m == 1 && j == 1)                return {1'b1, 8'h9C};
        if (m == 1 && j >= 2 && j <= 15)     return {1'b0, 8'(8'hA0 + j - 2)};
        return {1'b0, 8'(j)};
    endfunction

    task automatic tick();
        @(negedge clk);
        exp_cnt = (exp_cnt + 1) % 64;
        chk("lmfc_cnt", 32'(o_lmfc_cnt), 32'(exp_cnt));
        chk("rd_en", 32'(o_rd_en), 32'd1);
        err_hits += int'(o_sync_err);
    endtask

    task automatic cgs_check();
        chk("cgs_addr", 32'(o_addr), 32'h0BC);
        chk("cgs_k", 32'(o_k), 32'd1);
        chk("cgs_ready", 32'(o_data_ready), 32'd0);
    endtask

    task automatic ilas_check(input int m, input int j);
        logic [8:0] e;
        e = exp_ilas(m, j);
        chk($sformatf("ilas_addr_m%0d_j%0d", m, j), 32'(o_addr), 32'(e[7:0]));
        chk($sformatf("ilas_k_m%0d_j%0d", m, j), 32'(o_k), 32'(e[8]));
        chk($sformatf("ilas_cnt_m%0d_j%0d", m, j), 32'(o_lmfc_cnt), 32'(j));
        chk($sformatf("ilas_ready_m%0d_j%0d", m, j), 32'(o_data_ready),
            (m == 3 && j == 63) ? 32'd1 : 32'd0);
    endtask

    task automatic data_step(input bit rdy);
        chk("data_ready", 32'(o_data_ready), 32'(rdy));
        if (pend) begin
            chk("data_addr", 32'(o_addr), 32'(pend_val));
            chk("data_k", 32'(o_k), 32'd0);
        end
        if (rdy) begin
            i_data   = next_val;
            pend_val = next_val;
            next_val = next_val + 8'd1;
            pend     = 1'b1;
        end else begin
            pend = 1'b0;
        end
        tick();
    endtask

    task automatic wait_ilas();
        int guard;
        guard = 0;
        while (o_addr == 8'hBC && guard < 200) begin
            tick();
            guard++;
        end
        chk("ilas_start_addr", 32'(o_addr), 32'h01C);
        chk("ilas_start_cnt", 32'(o_lmfc_cnt), 32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        exp_cnt  = 0;
        err_hits = 0;
        pend     = 1'b0;
        pend_val = 8'h00;
        next_val = 8'h00;
        rst_n    = 1'b0;
        i_sync_n = 1'b0;
        i_data   = 8'h00;
        i_cfg    = '0;
        for (int n = 0; n < 14; n++) i_cfg[8*n +: 8] = 8'(8'hA0 + n);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_k", 32'(o_k), 32'd0);
        chk("rst_rd_en", 32'(o_rd_en), 32'd0);
        chk("rst_cnt", 32'(o_lmfc_cnt), 32'd0);
        chk("rst_err", 32'(o_sync_err), 32'd0);
        chk("rst_ready", 32'(o_data_ready), 32'd0);

        // CGS with SYNC~ held low, LMFC wraps
        rst_n = 1'b1;
        @(negedge clk);
        exp_cnt = 0;
        chk("first_cnt", 32'(o_lmfc_cnt), 32'd0);
        chk("first_rd_en", 32'(o_rd_en), 32'd1);
        cgs_check();
        repeat (70) begin
            tick();
            cgs_check();
        end

        // SYNC~ rises mid-multiframe: full ILAS
        i_sync_n = 1'b1;
        wait_ilas();
        for (int i = 0; i < 256; i++) begin
            if (i > 0) tick();
            ilas_check(i / 64, i % 64);
        end

        // Data phase follows the final /A/
        pend     = 1'b0;
        next_val = 8'h00;
        data_step(1'b1);
        chk("first_data_cnt", 32'(o_lmfc_cnt), 32'd0);
        chk("first_data_addr", 32'(o_addr), 32'h000);
        repeat (70) data_step(1'b1);
        chk("no_err_before_glitch", 32'(err_hits), 32'd0);

        // Two-cycle SYNC~ glitch in DATA
        i_sync_n = 1'b0;
        data_step(1'b1);
        data_step(1'b1);
        i_sync_n = 1'b1;
        repeat (12) data_step(1'b1);
        chk("glitch_err_pulses", 32'(err_hits), 32'd1);

        // Sustained SYNC~ loss in DATA
        i_sync_n = 1'b0;
        repeat (5) data_step(1'b1);
        data_step(1'b0);
        cgs_check();
        i_sync_n = 1'b1;
        chk("loss_no_err", 32'(err_hits), 32'd1);
        wait_ilas();

        // Sustained SYNC~ loss in ILAS
        for (int j = 0; j < 10; j++) begin
            if (j > 0) tick();
            ilas_check(0, j);
        end
        tick();
        i_sync_n = 1'b0;
        ilas_check(0, 10);
        for (int j = 11; j < 16; j++) begin
            tick();
            ilas_check(0, j);
        end
        tick();
        cgs_check();
        i_sync_n = 1'b1;
        wait_ilas();

        // Reset during ILAS multiframe 1
        for (int i = 0; i < 70; i++) begin
            if (i > 0) tick();
            ilas_check(i / 64, i % 64);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(o_addr), 32'd0);
        chk("mid_rst_k", 32'(o_k), 32'd0);
        chk("mid_rst_rd_en", 32'(o_rd_en), 32'd0);
        chk("mid_rst_cnt", 32'(o_lmfc_cnt), 32'd0);
        chk("mid_rst_err", 32'(o_sync_err), 32'd0);
        chk("mid_rst_ready", 32'(o_data_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_cnt = 0;
        chk("restart_cnt", 32'(o_lmfc_cnt), 32'd0);
        chk("restart_rd_en", 32'(o_rd_en), 32'd1);
        cgs_check();
        repeat (3) begin
            tick();
            cgs_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jesd_tx_link_fsm.md
# jesd_tx_link_fsm

Single-lane JESD204B transmit link-layer sequencer. It generates one octet per clock to the 8b/10b encoder. It runs Code Group Synchronization (CGS), the Initial Lane Alignment Sequence (ILAS) and user data phases under control of the receiver's SYNC~ signal. Its outputs drive the encoder stage's address, K-select and read-enable inputs directly. It keeps a free-running local multiframe (LMFC) octet counter.

## Interface
- `F`, default 2: octets per frame.
- `K`, default 32: frames per multiframe.
  - Legal range requires F*K between 17 and 1024.
- `ILAS_MF`, default 4: multiframes in ILAS. Minimum 2.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `i_sync_n` input, 1 bit: receiver SYNC~. Asynchronous to `clk`; low requests CGS.
- `i_cfg` input, 112 bits: ILAS link configuration octets 0..13. Octet n is `i_cfg[8n+7:8n]`; static while not in CGS.
- `i_data` input, 8 bits: user octet, captured when `o_data_ready`=1.
- `o_data_ready` output, 1 bit: combinational; the user octet is consumed this cycle.
- `o_addr` output, 8 bits: octet to encoder, HGFEDCBA.
- `o_k` output, 1 bit: 1 = control character, 0 = data.
- `o_rd_en` output, 1 bit: encoder read enable.
- `o_lmfc_cnt` output, clog2(F*K) bits: LMFC position of the octet currently on `o_addr`.
- `o_sync_err` output, 1 bit: one-cycle pulse after a short SYNC~ low pulse (error report).

## Operation
- SYNC~ handling:
  - `i_sync_n` passes through a 2-flop synchronizer; the result is `sync_s`. Synchronizer flops reset to 0.
- LMFC counter:
  - Free-running from reset, 0..F*K-1, wraps to 0.
  - Advances every cycle regardless of state.
- States: CGS, ILAS_WAIT, ILAS, DATA. Reset state is CGS.
- CGS:
  - Emit K28.5 (`o_addr`=0xBC, `o_k`=1).
  - Go to ILAS_WAIT when `sync_s`=1.
- ILAS_WAIT:
  - Emit K28.5.
  - Go to ILAS so that the first ILAS octet appears with `o_lmfc_cnt`=0.
  - If `sync_s`=0, return to CGS.
- ILAS: multiframe index m runs 0..ILAS_MF-1; j is the octet's LMFC position. Each octet is chosen as follows:
  - j=0: K28.0 (0x1C, k=1).
  - j=F*K-1: K28.3 (0x7C, k=1).
  - m=1, j=1: K28.4 (0x9C, k=1).
  - m=1, 2≤j≤15: `i_cfg` octet j-2, k=0.
  - Otherwise: data j[7:0], k=0.
  - After the last octet of multiframe ILAS_MF-1, go to DATA.
- DATA:
  - The octet captured from `i_data` is output with k=0.
  - No character replacement and no scrambling.
- `o_data_ready` is 1 when either:
  - state is DATA, or
  - state is ILAS, m=ILAS_MF-1 and the emitted j=F*K-1.
  - So the first data octet appears at `o_lmfc_cnt`=0.
- Loss of sync (ILAS or DATA):
  - A counter tracks consecutive cycles with `sync_s`=0.
  - On the 4th consecutive low cycle, enter CGS. The next emitted octet is K28.5 and `o_data_ready` drops.
  - A low run of 1-3 cycles ending with `sync_s`=1 produces an `o_sync_err` pulse in the cycle after the rise. The state is unaffected.
- In CGS and ILAS_WAIT, `sync_s` activity never asserts `o_sync_err`.
- All emitted K characters are in the encoder's valid K set, so the encoder never flags a K error.

## Timing
- Reset values: `o_addr`=0x00, `o_k`=0, `o_rd_en`=0, `o_lmfc_cnt`=0, `o_sync_err`=0, `o_data_ready`=0.
  - Internal LMFC counter, state and run counter are cleared.
- First edge after `rst_n` rises:
  - `o_addr`=0xBC, `o_k`=1, `o_rd_en`=1.
  - `o_rd_en` then stays 1 every cycle until reset.
- `o_addr`, `o_k` and `o_lmfc_cnt` are registered, and change together.
- `o_data_ready` is combinational from registered state only; it has no path from `i_data` or `i_sync_n`.
- `i_data` sampled at edge N appears on `o_addr` after edge N.
- SYNC~ latency:
  - `i_sync_n` high first sampled at edge N gives `sync_s`=1 after edge N+1.
  - The state is ILAS_WAIT after edge N+2.
- ILAS duration is exactly ILAS_MF*F*K octets.
- Reset asserted mid-operation forces the reset values immediately.
  - Restart is always via CGS with the LMFC counter from 0.

## Test plan
1. Reset release with `i_sync_n`=0 held (F=2, K=32) -> continuous 0xBC/k=1/rd_en=1 and `o_lmfc_cnt` wrapping 63→0; `o_data_ready`=0 throughout.
2. Raise `i_sync_n` mid-multiframe, with `i_cfg` octet n = 0xA0+n -> K28.5 until `o_lmfc_cnt`=0. Then 4×64 ILAS octets:
   - Every multiframe: 0x1C at cnt 0 and 0x7C at cnt 63.
   - Multiframe 1: 0x9C at cnt 1 and 0xA0..0xAD at cnt 2..15.
   - Other octets: data equal to cnt.
3. Continue case 2, driving `i_data` = incrementing from 0x00 -> 0x00 appears at `o_lmfc_cnt`=0 right after the final 0x7C, k=0; `o_data_ready` rose in the /A/ cycle; subsequent octets are in order with none dropped.
4. In DATA, drop `i_sync_n` for 2 cycles -> one `o_sync_err` pulse; data flow is uninterrupted.
5. In DATA (and separately in ILAS), hold `i_sync_n` low for 6 cycles -> K28.5 after the 4th `sync_s`-low cycle, `o_data_ready`=0; raising SYNC~ restarts ILAS at the next `o_lmfc_cnt`=0.
6. Assert `rst_n` during ILAS multiframe 1 -> outputs go to reset values at once; after release, CGS resumes with `o_lmfc_cnt` from 0.
